swap_cfg_ctrl: RTL and testbench

Control-side counterpart of the initiator-port swap remapper in the AXI crossbar address-decode path. Accepts per-port swap entries into a shadow table over a valid/ready write channel. On request, it commits them atomically to the active `select`/`source`/`target` vectors that drive the remapper. A commit is applied only after every initiator port has drained its outstanding transactions, so no in-flight burst ever sees a routing change.

---
 rtl/swap_cfg_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_swap_cfg_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_cfg_ctrl.sv
// swap_cfg_ctrl: shadow/active swap table controller for the initiator-port remapper.
// Shadow entries are written over a valid/ready channel. A commit first drains every
// initiator port's outstanding transactions, then copies the shadow table to the active
// outputs in one edge.
// Optional feature macro: SWAP_DRAIN_TIMEOUT_EN adds a drain timeout. When it fires, the
// controller aborts the commit and pulses commit_err_o.
module swap_cfg_ctrl #(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned LOG_N_INIT  = 3,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // shadow-entry write channel
  input  logic                              cfg_valid_i,
  output logic                              cfg_ready_o,
  input  logic [LOG_N_INIT-1:0]             cfg_port_i,
  input  logic                              cfg_sel_i,
  input  logic [LOG_N_INIT-1:0]             cfg_src_i,
  input  logic [LOG_N_INIT-1:0]             cfg_tgt_i,
  // commit control
  input  logic                              commit_i,
  output logic                              commit_busy_o,
  output logic                              commit_done_o,
  output logic                              commit_err_o,
  // per-port traffic observation
  input  logic [N_INIT_PORT-1:0]            req_fire_i,
  input  logic [N_INIT_PORT-1:0]            rsp_fire_i,
  output logic [N_INIT_PORT-1:0]            block_o,
  // active remap table
  output logic [N_INIT_PORT-1:0]            select_o,
  output logic [N_INIT_PORT*LOG_N_INIT-1:0] source_o,
  output logic [N_INIT_PORT*LOG_N_INIT-1:0] target_o,
  output logic                              cnt_err_o
);

  // Elaboration-time sanity checks on the parameter set
  if (TIMEOUT < 1) begin : gen_timeout_check
    $error("swap_cfg_ctrl: TIMEOUT must be at least 1");
  end
  if (N_INIT_PORT > (1 << LOG_N_INIT)) begin : gen_index_check
    $error("swap_cfg_ctrl: LOG_N_INIT too narrow for N_INIT_PORT");
  end

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StApply
  } state_e;

  state_e state_q, state_d;

  logic                  sh_sel_q [N_INIT_PORT];
  logic [LOG_N_INIT-1:0] sh_src_q [N_INIT_PORT];
  logic [LOG_N_INIT-1:0] sh_tgt_q [N_INIT_PORT];

  logic [CNT_W-1:0] cnt_q [N_INIT_PORT];
  logic [CNT_W-1:0] cnt_d [N_INIT_PORT];
  logic             cnt_err_set;
  logic             all_zero;
  logic             cnt_err_q;

  logic [N_INIT_PORT-1:0]            select_q;
  logic [N_INIT_PORT*LOG_N_INIT-1:0] source_q;
  logic [N_INIT_PORT*LOG_N_INIT-1:0] target_q;
  logic                              done_q;

  logic cfg_fire;
  logic apply_en;
  logic timeout_hit;

  assign cfg_fire = cfg_valid_i & cfg_ready_o;

  // Shadow table: written only while idle. An out-of-range index matches no entry,
  // so the write is accepted and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < int'(N_INIT_PORT); p++) begin
        sh_sel_q[p] <= 1'b0;
        sh_src_q[p] <= '0;
        sh_tgt_q[p] <= '0;
      end
    end else if (cfg_fire) begin
      for (int p = 0; p < int'(N_INIT_PORT); p++) begin
        if (cfg_port_i == LOG_N_INIT'(p)) begin
          sh_sel_q[p] <= cfg_sel_i;
          sh_src_q[p] <= cfg_src_i;
          sh_tgt_q[p] <= cfg_tgt_i;
        end
      end
    end
  end

  // Outstanding-transaction counters: saturate at both ends and flag the misuse
  always_comb begin
    cnt_err_set = 1'b0;
    all_zero    = 1'b1;
    for (int p = 0; p < int'(N_INIT_PORT); p++) begin
      cnt_d[p] = cnt_q[p];
      if (req_fire_i[p] && !rsp_fire_i[p]) begin
        if (cnt_q[p] == {CNT_W{1'b1}}) begin
          cnt_err_set = 1'b1;
        end else begin
          cnt_d[p] = cnt_q[p] + CNT_W'(1);
        end
      end else if (!req_fire_i[p] && rsp_fire_i[p]) begin
        if (cnt_q[p] == '0) begin
          cnt_err_set = 1'b1;
        end else begin
          cnt_d[p] = cnt_q[p] - CNT_W'(1);
        end
      end
      if (cnt_q[p] != '0) begin
        all_zero = 1'b0;
      end
    end
  end

  // Counter state and the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < int'(N_INIT_PORT); p++) begin
        cnt_q[p] <= '0;
      end
      cnt_err_q <= 1'b0;
    end else begin
      for (int p = 0; p < int'(N_INIT_PORT); p++) begin
        cnt_q[p] <= cnt_d[p];
      end
      cnt_err_q <= cnt_err_q | cnt_err_set;
    end
  end

`ifdef SWAP_DRAIN_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TimerW-1:0] timer_q;
  logic              err_q;

  // Drain timer: counts cycles spent in DRAIN, cleared whenever DRAIN is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_q == StDrain && state_d == StDrain) begin
      timer_q <= timer_q + TimerW'(1);
    end else begin
      timer_q <= '0;
    end
  end

  // Abort pulse is registered so it appears in the first cycle back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign commit_err_o = err_q;
`else
  assign commit_err_o = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: drain decision uses registered counter values only
  always_comb begin
    state_d     = state_q;
    apply_en    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      StIdle: begin
        if (commit_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (all_zero) begin
          state_d = StApply;
        end
`ifdef SWAP_DRAIN_TIMEOUT_EN
        else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          state_d     = StIdle;
          timeout_hit = 1'b1;
        end
`endif
      end
      StApply: begin
        state_d  = StIdle;
        apply_en = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Active table: changes only on the APPLY edge, together with the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      select_q <= '0;
      source_q <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= apply_en;
      if (apply_en) begin
        for (int p = 0; p < int'(N_INIT_PORT); p++) begin
          select_q[p]                           <= sh_sel_q[p];
          source_q[p*LOG_N_INIT +: LOG_N_INIT] <= sh_src_q[p];
          target_q[p*LOG_N_INIT +: LOG_N_INIT] <= sh_tgt_q[p];
        end
      end
    end
  end

  assign cfg_ready_o   = (state_q == StIdle);
  assign commit_busy_o = (state_q != StIdle);
  assign block_o       = {N_INIT_PORT{commit_busy_o}};
  assign commit_done_o = done_q;
  assign select_o      = select_q;
  assign source_o      = source_q;
  assign target_o      = target_q;
  assign cnt_err_o     = cnt_err_q;

endmodule

// File: tb/tb_swap_cfg_ctrl.sv
// Self-checking bench for swap_cfg_ctrl: a shadow-table model feeds a scoreboard queue
// at each commit, and the monitor pops it on commit_done_o / commit_err_o.
module tb_swap_cfg_ctrl;
  localparam int unsigned N  = 8;
  localparam int unsigned L  = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid_i = 1'b0;
  logic           cfg_ready_o;
  logic [L-1:0]   cfg_port_i = '0;
  logic           cfg_sel_i = 1'b0;
  logic [L-1:0]   cfg_src_i = '0;
  logic [L-1:0]   cfg_tgt_i = '0;
  logic           commit_i = 1'b0;
  logic           commit_busy_o;
  logic           commit_done_o;
  logic           commit_err_o;
  logic [N-1:0]   req_fire_i = '0;
  logic [N-1:0]   rsp_fire_i = '0;
  logic [N-1:0]   block_o;
  logic [N-1:0]   select_o;
  logic [N*L-1:0] source_o;
  logic [N*L-1:0] target_o;
  logic           cnt_err_o;

  always #5 clk = ~clk;

  swap_cfg_ctrl #(
    .N_INIT_PORT (N),
    .LOG_N_INIT  (L),
    .CNT_W       (CW),
    .TIMEOUT     (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_port_i    (cfg_port_i),
    .cfg_sel_i     (cfg_sel_i),
    .cfg_src_i     (cfg_src_i),
    .cfg_tgt_i     (cfg_tgt_i),
    .commit_i      (commit_i),
    .commit_busy_o (commit_busy_o),
    .commit_done_o (commit_done_o),
    .commit_err_o  (commit_err_o),
    .req_fire_i    (req_fire_i),
    .rsp_fire_i    (rsp_fire_i),
    .block_o       (block_o),
    .select_o      (select_o),
    .source_o      (source_o),
    .target_o      (target_o),
    .cnt_err_o     (cnt_err_o)
  );

  typedef struct packed {
    logic [N-1:0]   sel;
    logic [N*L-1:0] src;
    logic [N*L-1:0] tgt;
  } tbl_t;

  tbl_t         exp_q[$];
  tbl_t         act_model = '0;
  tbl_t         mon_e;
  logic         m_sel [N];
  logic [L-1:0] m_src [N];
  logic [L-1:0] m_tgt [N];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic tbl_t snapshot();
    tbl_t t;
    for (int p = 0; p < int'(N); p++) begin
      t.sel[p]       = m_sel[p];
      t.src[p*L +: L] = m_src[p];
      t.tgt[p*L +: L] = m_tgt[p];
    end
    return t;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < int'(N); p++) begin
      m_sel[p] = 1'b0;
      m_src[p] = '0;
      m_tgt[p] = '0;
    end
    exp_q.delete();
    act_model = '0;
  endtask

  // Called at a negedge while idle; returns at the next negedge
  task automatic cfg_write(input int p, input bit s, input int src, input int tgt);
    cfg_valid_i = 1'b1;
    cfg_port_i  = L'(p);
    cfg_sel_i   = s;
    cfg_src_i   = L'(src);
    cfg_tgt_i   = L'(tgt);
    m_sel[p] = s;
    m_src[p] = L'(src);
    m_tgt[p] = L'(tgt);
    @(negedge clk);
    cfg_valid_i = 1'b0;
  endtask

  task automatic commit();
    commit_i = 1'b1;
    exp_q.push_back(snapshot());
    @(negedge clk);
    commit_i = 1'b0;
  endtask

  // Scoreboard side: done must match the oldest queued table, err must leave it untouched
  always @(negedge clk) begin
    if (rst_n && commit_done_o) begin
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        act_model = mon_e;
        check_eq("done_select", 32'(select_o), 32'(mon_e.sel));
        check_eq("done_source", 32'(source_o), 32'(mon_e.src));
        check_eq("done_target", 32'(target_o), 32'(mon_e.tgt));
      end
    end
    if (rst_n && commit_err_o) begin
      if (exp_q.size() == 0) begin
        check_eq("err_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("err_select_kept", 32'(select_o), 32'(act_model.sel));
        check_eq("err_source_kept", 32'(source_o), 32'(act_model.src));
        check_eq("err_target_kept", 32'(target_o), 32'(act_model.tgt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_select"}, 32'(select_o), 32'd0);
    check_eq({tag, "_source"}, 32'(source_o), 32'd0);
    check_eq({tag, "_target"}, 32'(target_o), 32'd0);
    check_eq({tag, "_block"}, 32'(block_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(commit_busy_o), 32'd0);
    check_eq({tag, "_ready"}, 32'(cfg_ready_o), 32'd1);
    check_eq({tag, "_done"}, 32'(commit_done_o), 32'd0);
    check_eq({tag, "_err"}, 32'(commit_err_o), 32'd0);
    check_eq({tag, "_cnt_err"}, 32'(cnt_err_o), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic commit with no traffic: 3-cycle latency, block high exactly two cycles
    cfg_write(2, 1'b1, 5, 2);
    commit();
    check_eq("t1_block_c1", 32'(block_o), 32'hff);
    check_eq("t1_busy_c1", 32'(commit_busy_o), 32'd1);
    check_eq("t1_ready_c1", 32'(cfg_ready_o), 32'd0);
    check_eq("t1_select_c1", 32'(select_o), 32'd0);
    @(negedge clk);
    check_eq("t1_block_c2", 32'(block_o), 32'hff);
    check_eq("t1_done_c2", 32'(commit_done_o), 32'd0);
    check_eq("t1_select_c2", 32'(select_o), 32'd0);
    @(negedge clk);
    check_eq("t1_block_c3", 32'(block_o), 32'd0);
    check_eq("t1_done_c3", 32'(commit_done_o), 32'd1);
    check_eq("t1_select_c3", 32'(select_o), 32'h04);
    check_eq("t1_source2", 32'(source_o[8:6]), 32'd5);
    check_eq("t1_target2", 32'(target_o[8:6]), 32'd2);
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(commit_done_o), 32'd0);

    // Drain waits for three outstanding responses on port 1
    cfg_write(1, 1'b1, 3, 6);
    req_fire_i = 8'h02;
    repeat (3) @(negedge clk);
    req_fire_i = '0;
    commit();
    // commit and cfg writes outside IDLE are ignored
    commit_i    = 1'b1;
    cfg_valid_i = 1'b1;
    cfg_port_i  = 3'd7;
    cfg_sel_i   = 1'b1;
    cfg_src_i   = 3'd1;
    cfg_tgt_i   = 3'd1;
    check_eq("t2_ready_drain", 32'(cfg_ready_o), 32'd0);
    @(negedge clk);
    commit_i    = 1'b0;
    cfg_valid_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      repeat (3) begin
        check_eq("t2_block_hold", 32'(block_o), 32'hff);
        check_eq("t2_no_done", 32'(commit_done_o), 32'd0);
        check_eq("t2_select_hold", 32'(select_o), 32'h04);
        @(negedge clk);
      end
      rsp_fire_i = 8'h02;
      @(negedge clk);
      rsp_fire_i = '0;
    end
    check_eq("t2_block_last", 32'(block_o), 32'hff);
    check_eq("t2_done_last", 32'(commit_done_o), 32'd0);
    @(negedge clk);
    check_eq("t2_block_apply", 32'(block_o), 32'hff);
    check_eq("t2_done_apply", 32'(commit_done_o), 32'd0);
    @(negedge clk);
    check_eq("t2_done", 32'(commit_done_o), 32'd1);
    check_eq("t2_select", 32'(select_o), 32'h06);
    check_eq("t2_source1", 32'(source_o[5:3]), 32'd3);

    // Simultaneous req/rsp with count 1 leaves the count at 1
    cfg_write(0, 1'b1, 7, 1);
    req_fire_i = 8'h01;
    @(negedge clk);
    req_fire_i = '0;
    commit();
    repeat (6) begin
      req_fire_i = 8'h01;
      rsp_fire_i = 8'h01;
      @(negedge clk);
      check_eq("t3_busy", 32'(commit_busy_o), 32'd1);
      check_eq("t3_no_done", 32'(commit_done_o), 32'd0);
    end
    req_fire_i = '0;
    rsp_fire_i = '0;
    repeat (2) begin
      @(negedge clk);
      check_eq("t3_busy_idle", 32'(commit_busy_o), 32'd1);
    end
    rsp_fire_i = 8'h01;
    @(negedge clk);
    rsp_fire_i = '0;
    check_eq("t3_busy_last", 32'(commit_busy_o), 32'd1);
    @(negedge clk);
    check_eq("t3_done_apply", 32'(commit_done_o), 32'd0);
    @(negedge clk);
    check_eq("t3_done", 32'(commit_done_o), 32'd1);
    check_eq("t3_select", 32'(select_o), 32'h07);
    @(negedge clk);

    // Saturation: 16 requests on port 3 hold the counter at 15 and flag the error
    for (int i = 0; i < 16; i++) begin
      req_fire_i = 8'h08;
      @(negedge clk);
      if (i == 14) check_eq("t4_cnt_err_15", 32'(cnt_err_o), 32'd0);
    end
    req_fire_i = '0;
    check_eq("t4_cnt_err_16", 32'(cnt_err_o), 32'd1);
    rsp_fire_i = 8'h08;
    repeat (14) @(negedge clk);
    rsp_fire_i = '0;
    cfg_write(3, 1'b1, 0, 3);
    commit();
    repeat (4) begin
      check_eq("t4_busy_sat", 32'(commit_busy_o), 32'd1);
      check_eq("t4_no_done", 32'(commit_done_o), 32'd0);
      @(negedge clk);
    end
    rsp_fire_i = 8'h08;
    @(negedge clk);
    rsp_fire_i = '0;
    check_eq("t4_done_drain", 32'(commit_done_o), 32'd0);
    @(negedge clk);
    check_eq("t4_done_apply", 32'(commit_done_o), 32'd0);
    @(negedge clk);
    check_eq("t4_done", 32'(commit_done_o), 32'd1);
    check_eq("t4_select", 32'(select_o), 32'h0f);
    check_eq("t4_cnt_err_sticky", 32'(cnt_err_o), 32'd1);

    // Underflow after reset
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst2");
    rst_n = 1'b1;
    rsp_fire_i = 8'h10;
    @(negedge clk);
    rsp_fire_i = '0;
    check_eq("t4_underflow", 32'(cnt_err_o), 32'd1);

`ifdef SWAP_DRAIN_TIMEOUT_EN
    // Drain timeout: abort, keep active table, retain shadow
    begin
      int cyc;
      bit found;
      cfg_write(5, 1'b1, 2, 4);
      req_fire_i = 8'h20;
      @(negedge clk);
      req_fire_i = '0;
      commit();
      cyc   = 1;
      found = 1'b0;
      while (cyc < 40 && !found) begin
        if (commit_err_o) found = 1'b1;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
      check_eq("t5_err_cycle", 32'(cyc), 32'd21);
      check_eq("t5_select_kept", 32'(select_o), 32'd0);
      check_eq("t5_ready", 32'(cfg_ready_o), 32'd1);
      @(negedge clk);
      check_eq("t5_err_pulse", 32'(commit_err_o), 32'd0);
      rsp_fire_i = 8'h20;
      @(negedge clk);
      rsp_fire_i = '0;
      commit();
      @(negedge clk);
      @(negedge clk);
      check_eq("t5_retry_done", 32'(commit_done_o), 32'd1);
      check_eq("t5_retry_select", 32'(select_o), 32'h20);
    end
`else
    // Without the timeout, drain waits as long as traffic is outstanding
    cfg_write(5, 1'b1, 2, 4);
    req_fire_i = 8'h20;
    @(negedge clk);
    req_fire_i = '0;
    commit();
    repeat (25) begin
      check_eq("t5_busy_wait", 32'(commit_busy_o), 32'd1);
      check_eq("t5_no_err", 32'(commit_err_o), 32'd0);
      @(negedge clk);
    end
    rsp_fire_i = 8'h20;
    @(negedge clk);
    rsp_fire_i = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_late_done", 32'(commit_done_o), 32'd1);
    check_eq("t5_late_select", 32'(select_o), 32'h20);
`endif

    // Reset during DRAIN: immediate reset values, no done pulse afterwards
    cfg_write(7, 1'b1, 6, 6);
    commit();
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_pre_select", 32'(select_o[7]), 32'd1);
    req_fire_i = 8'h40;
    @(negedge clk);
    req_fire_i = '0;
    commit();
    repeat (3) @(negedge clk);
    check_eq("t6_in_drain", 32'(commit_busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("t6_no_done", 32'(commit_done_o), 32'd0);
      check_eq("t6_idle", 32'(commit_busy_o), 32'd0);
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
